// File: rtl/pipe_hazard_pkg.sv
// Shared encodings for the ID-stage hazard / forwarding / mul-div scoreboard.
//   FWD_*   : operand source select driven onto fwda / fwdb
//   CAUSE_* : stall_cause encodings
//   md_lat_ok() : legality check for the mul/div latency parameter
package pipe_hazard_pkg;

  localparam int unsigned MD_CNT_W   = 8;
  localparam int unsigned MD_LAT_MIN = 1;
  localparam int unsigned MD_LAT_MAX = 255;

  localparam logic [1:0] FWD_RF   = 2'b00;
  localparam logic [1:0] FWD_EALU = 2'b01;
  localparam logic [1:0] FWD_MALU = 2'b10;
  localparam logic [1:0] FWD_MMEM = 2'b11;

  localparam logic [1:0] CAUSE_NONE = 2'b00;
  localparam logic [1:0] CAUSE_LU   = 2'b01;
  localparam logic [1:0] CAUSE_MD   = 2'b10;
  localparam logic [1:0] CAUSE_BOTH = 2'b11;

  function automatic bit md_lat_ok(input int unsigned lat);
    return (lat >= MD_LAT_MIN) && (lat <= MD_LAT_MAX);
  endfunction

endpackage

// File: rtl/pipe_hazard_scoreboard_md_cnt.sv
// Mul/div occupancy scoreboard: countdown loaded on an accepted issue.
// Ports:
//   clk, rst_n : clock, async active-low reset
//   issue      : mul/div issue accepted this cycle
//   md_busy    : unit occupied (countdown nonzero)
//   md_done    : one-cycle pulse the cycle after the countdown leaves 1
module md_scoreboard_cnt
  import pipe_hazard_pkg::*;
#(
  parameter int unsigned MD_LAT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic issue,
  output logic md_busy,
  output logic md_done
);

  logic [MD_CNT_W-1:0] md_cnt_q, md_cnt_d;
  logic                md_done_q, md_done_d;

  // Next countdown value and completion pulse.
  always_comb begin
    md_cnt_d  = md_cnt_q;
    md_done_d = 1'b0;
    if (issue) begin
      md_cnt_d = MD_CNT_W'(MD_LAT);
    end else if (md_cnt_q != '0) begin
      md_cnt_d = md_cnt_q - MD_CNT_W'(1);
    end
    // A fresh load in the final busy cycle suppresses the pulse.
    md_done_d = (md_cnt_q == MD_CNT_W'(1)) && !issue;
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      md_cnt_q  <= '0;
      md_done_q <= 1'b0;
    end else begin
      md_cnt_q  <= md_cnt_d;
      md_done_q <= md_done_d;
    end
  end

  assign md_busy = (md_cnt_q != '0);
  assign md_done = md_done_q;

endmodule

// File: rtl/pipe_hazard_scoreboard.sv
// ID-stage hazard unit: operand forwarding from E/M, load-use stall,
// mul/div busy stall with countdown scoreboard, saturating stall counter.
// Ports:
//   clk, rst_n                : clock, async active-low reset
//   id_*                      : ID-stage instruction operands / mul-div usage
//   e_wr/e_load/e_rn          : E-stage destination info
//   m_wr/m_load/m_rn          : M-stage destination info
//   flush                     : ID instruction squashed this cycle
//   clr_stats                 : synchronous clear of stall_cnt
//   stall, stall_cause        : combinational stall request and its cause
//   fwda, fwdb                : combinational operand source selects
//   md_busy, md_done          : mul/div occupancy and completion pulse
//   stall_cnt                 : saturating count of stalled cycles
module pipe_hazard_scoreboard
  import pipe_hazard_pkg::*;
#(
  parameter int unsigned AW     = 5,
  parameter int unsigned MD_LAT = 4,
  parameter int unsigned SCW    = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           id_valid,
  input  logic [AW-1:0]  id_rs,
  input  logic [AW-1:0]  id_rt,
  input  logic           id_use_rs,
  input  logic           id_use_rt,
  input  logic           id_md_start,
  input  logic           id_hilo_rd,
  input  logic           e_wr,
  input  logic           e_load,
  input  logic [AW-1:0]  e_rn,
  input  logic           m_wr,
  input  logic           m_load,
  input  logic [AW-1:0]  m_rn,
  input  logic           flush,
  input  logic           clr_stats,
  output logic           stall,
  output logic [1:0]     stall_cause,
  output logic [1:0]     fwda,
  output logic [1:0]     fwdb,
  output logic           md_busy,
  output logic           md_done,
  output logic [SCW-1:0] stall_cnt
);

  if (!md_lat_ok(MD_LAT)) begin : g_bad_md_lat
    $error("pipe_hazard_scoreboard: MD_LAT must be in 1..255");
  end

  logic           e_hit_rs, e_hit_rt, m_hit_rs, m_hit_rt;
  logic           lu, mh;
  logic           md_issue;
  logic           md_busy_w;
  logic [SCW-1:0] stall_cnt_q, stall_cnt_d;

  // Register-number matches against live destinations; r0 never matches.
  assign e_hit_rs = e_wr && (e_rn != '0) && (e_rn == id_rs);
  assign e_hit_rt = e_wr && (e_rn != '0) && (e_rn == id_rt);
  assign m_hit_rs = m_wr && (m_rn != '0) && (m_rn == id_rs);
  assign m_hit_rt = m_wr && (m_rn != '0) && (m_rn == id_rt);

  // Forwarding select; an E-stage load has no data yet, so it falls through to M.
  always_comb begin
    fwda = FWD_RF;
    fwdb = FWD_RF;
    if (e_hit_rs && !e_load) begin
      fwda = FWD_EALU;
    end else if (m_hit_rs) begin
      fwda = m_load ? FWD_MMEM : FWD_MALU;
    end
    if (e_hit_rt && !e_load) begin
      fwdb = FWD_EALU;
    end else if (m_hit_rt) begin
      fwdb = m_load ? FWD_MMEM : FWD_MALU;
    end
  end

  // Hazard detection and stall request.
  always_comb begin
    lu          = id_valid && e_load &&
                  ((id_use_rs && e_hit_rs) || (id_use_rt && e_hit_rt));
    mh          = id_valid && (id_hilo_rd || id_md_start) && md_busy_w;
    stall       = (lu || mh) && !flush;
    stall_cause = flush ? CAUSE_NONE : {mh, lu};
    md_issue    = id_valid && id_md_start && !stall && !flush;
  end

  md_scoreboard_cnt #(
    .MD_LAT (MD_LAT)
  ) u_md_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .issue   (md_issue),
    .md_busy (md_busy_w),
    .md_done (md_done)
  );

  assign md_busy = md_busy_w;

  // Saturating stall counter; clear wins over increment.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (clr_stats) begin
      stall_cnt_d = '0;
    end else if (stall && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + SCW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_scoreboard.sv
// Self-checking bench for pipe_hazard_scoreboard: directed scenarios followed
// by randomized traffic, all checked against a cycle-indexed reference model.
module tb_pipe_hazard_scoreboard;

  localparam int unsigned AW     = 5;
  localparam int unsigned MD_LAT = 4;
  localparam int unsigned SCW    = 4;
  localparam int          CNT_MAX = (1 << SCW) - 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          id_valid, id_use_rs, id_use_rt, id_md_start, id_hilo_rd;
  logic [AW-1:0] id_rs, id_rt, e_rn, m_rn;
  logic          e_wr, e_load, m_wr, m_load, flush, clr_stats;
  logic          stall, md_busy, md_done;
  logic [1:0]    stall_cause, fwda, fwdb;
  logic [SCW-1:0] stall_cnt;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state: cycle index, cycle of last accepted issue, counter.
  int cyc    = 0;
  int t_iss  = -1000;
  int cnt_m  = 0;

  pipe_hazard_scoreboard #(
    .AW (AW), .MD_LAT (MD_LAT), .SCW (SCW)
  ) dut (
    .clk (clk), .rst_n (rst_n),
    .id_valid (id_valid), .id_rs (id_rs), .id_rt (id_rt),
    .id_use_rs (id_use_rs), .id_use_rt (id_use_rt),
    .id_md_start (id_md_start), .id_hilo_rd (id_hilo_rd),
    .e_wr (e_wr), .e_load (e_load), .e_rn (e_rn),
    .m_wr (m_wr), .m_load (m_load), .m_rn (m_rn),
    .flush (flush), .clr_stats (clr_stats),
    .stall (stall), .stall_cause (stall_cause),
    .fwda (fwda), .fwdb (fwdb),
    .md_busy (md_busy), .md_done (md_done), .stall_cnt (stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int fwd_exp(input logic [AW-1:0] src);
    if (e_wr && e_rn != 0 && e_rn == src && !e_load) return 1;
    if (m_wr && m_rn != 0 && m_rn == src) return m_load ? 3 : 2;
    return 0;
  endfunction

  function automatic bit busy_exp();
    return (cyc > t_iss) && (cyc <= t_iss + int'(MD_LAT));
  endfunction

  task automatic idle();
    id_valid = 0; id_use_rs = 0; id_use_rt = 0; id_md_start = 0; id_hilo_rd = 0;
    id_rs = '0; id_rt = '0; e_wr = 0; e_load = 0; e_rn = '0;
    m_wr = 0; m_load = 0; m_rn = '0; flush = 0; clr_stats = 0;
  endtask

  // Check every output against the model for the current cycle, then advance.
  task automatic tick();
    bit lu, mh, st;
    #1;
    lu = id_valid && e_wr && e_load && e_rn != 0 &&
         ((id_use_rs && e_rn == id_rs) || (id_use_rt && e_rn == id_rt));
    mh = id_valid && (id_hilo_rd || id_md_start) && busy_exp();
    st = (lu || mh) && !flush;
    check("stall", 32'(stall), 32'(st));
    check("cause", 32'(stall_cause), flush ? 32'd0 : 32'({mh, lu}));
    check("fwda", 32'(fwda), 32'(fwd_exp(id_rs)));
    check("fwdb", 32'(fwdb), 32'(fwd_exp(id_rt)));
    check("md_busy", 32'(md_busy), 32'(busy_exp()));
    check("md_done", 32'(md_done), 32'(cyc == t_iss + int'(MD_LAT) + 1));
    check("stall_cnt", 32'(stall_cnt), 32'(cnt_m));
    @(posedge clk);
    if (id_valid && id_md_start && !st && !flush) t_iss = cyc;
    if (clr_stats) cnt_m = 0;
    else if (st && cnt_m < CNT_MAX) cnt_m++;
    cyc++;
    #1;
    idle();
  endtask

  task automatic do_reset();
    rst_n = 0;
    #1;
    check("rst_busy", 32'(md_busy), 32'd0);
    check("rst_done", 32'(md_done), 32'd0);
    check("rst_cnt", 32'(stall_cnt), 32'd0);
    t_iss = -1000;
    cnt_m = 0;
    @(posedge clk);
    cyc++;
    #1;
    rst_n = 1;
  endtask

  initial begin
    idle();
    rst_n = 1;
    #3;
    do_reset();

    // E ALU result beats M load data for the same register.
    id_valid = 1; id_rs = 5'd8; id_use_rs = 1;
    e_wr = 1; e_rn = 5'd8; m_wr = 1; m_load = 1; m_rn = 5'd8;
    #1; check("fwda_e_prio", 32'(fwda), 32'd1); check("nostall", 32'(stall), 32'd0);
    tick();
    id_valid = 1; id_rs = 5'd8; id_use_rs = 1; m_wr = 1; m_load = 1; m_rn = 5'd8;
    #1; check("fwda_mmem", 32'(fwda), 32'd3);
    tick();

    // Load-use on rt; then the same with destination r0.
    id_valid = 1; id_rt = 5'd9; id_use_rt = 1; e_wr = 1; e_load = 1; e_rn = 5'd9;
    #1; check("lu_stall", 32'(stall), 32'd1); check("lu_cause", 32'(stall_cause), 32'd1);
    tick();
    id_valid = 1; id_rt = 5'd0; id_use_rt = 1; e_wr = 1; e_load = 1; e_rn = 5'd0;
    #1; check("r0_stall", 32'(stall), 32'd0); check("r0_fwdb", 32'(fwdb), 32'd0);
    tick();

    // Mul issue then mflo in ID: four stall cycles, done on the fifth.
    clr_stats = 1; tick();
    id_valid = 1; id_md_start = 1; tick();
    for (int i = 0; i < int'(MD_LAT); i++) begin
      id_valid = 1; id_hilo_rd = 1;
      #1; check("md_stall", 32'(stall), 32'd1); check("md_cause", 32'(stall_cause), 32'd2);
      check("md_done_early", 32'(md_done), 32'd0);
      tick();
    end
    // Back-to-back issue in the done cycle is accepted.
    id_valid = 1; id_md_start = 1;
    #1; check("md_done_pulse", 32'(md_done), 32'd1); check("b2b_stall", 32'(stall), 32'd0);
    check("md_cnt4", 32'(stall_cnt), 32'd4);
    tick();
    #1; check("b2b_busy", 32'(md_busy), 32'd1);

    // Both causes at once, then the same request squashed by flush.
    id_valid = 1; id_hilo_rd = 1; id_rs = 5'd3; id_use_rs = 1; e_wr = 1; e_load = 1; e_rn = 5'd3;
    #1; check("both_cause", 32'(stall_cause), 32'd3);
    tick();
    id_valid = 1; id_md_start = 1; id_rs = 5'd3; id_use_rs = 1;
    e_wr = 1; e_load = 1; e_rn = 5'd3; flush = 1;
    #1; check("flush_stall", 32'(stall), 32'd0);
    tick();
    for (int i = 0; i < 4; i++) tick();
    // Flushed mul/div start while idle must not issue.
    id_valid = 1; id_md_start = 1; flush = 1; tick();
    #1; check("flush_noissue", 32'(md_busy), 32'd0);

    // Reset two cycles into a countdown.
    id_valid = 1; id_md_start = 1; tick();
    tick();
    do_reset();
    for (int i = 0; i < int'(MD_LAT) + 2; i++) tick();

    // Saturation of the narrow counter and clear priority.
    for (int i = 0; i < 20; i++) begin
      id_valid = 1; id_rs = 5'd4; id_use_rs = 1; e_wr = 1; e_load = 1; e_rn = 5'd4;
      tick();
    end
    #1; check("sat", 32'(stall_cnt), 32'(CNT_MAX));
    id_valid = 1; id_rs = 5'd4; id_use_rs = 1; e_wr = 1; e_load = 1; e_rn = 5'd4; clr_stats = 1;
    tick();
    #1; check("clr_prio", 32'(stall_cnt), 32'd0);

    // Randomized traffic on a small register set to force collisions.
    for (int i = 0; i < 600; i++) begin
      id_valid    = ($urandom_range(0, 3) != 0);
      id_rs       = AW'($urandom_range(0, 3));
      id_rt       = AW'($urandom_range(0, 3));
      id_use_rs   = 1'($urandom);
      id_use_rt   = 1'($urandom);
      id_md_start = ($urandom_range(0, 5) == 0);
      id_hilo_rd  = ($urandom_range(0, 3) == 0);
      e_wr        = 1'($urandom);
      e_load      = 1'($urandom);
      e_rn        = AW'($urandom_range(0, 3));
      m_wr        = 1'($urandom);
      m_load      = 1'($urandom);
      m_rn        = AW'($urandom_range(0, 3));
      flush       = ($urandom_range(0, 7) == 0);
      clr_stats   = ($urandom_range(0, 29) == 0);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_scoreboard.md
# pipe_hazard_scoreboard

Parametrised hazard, forwarding and multi-cycle scoreboard unit for the five-stage dynamic pipeline CPU, sitting beside the ID-stage decoder. It resolves operand forwarding from the E and M stages and raises a load-use stall. It also tracks an in-flight multi-cycle mul/div unit with a countdown scoreboard, stalling HI/LO consumers and new mul/div issues until the unit completes. A saturating stall-cycle counter supports performance measurement.

## Interface
- AW, 5, register-number width (2**AW architectural registers; register 0 never forwarded or hazarded)
- MD_LAT, 4, busy cycles of the mul/div unit after issue; legal range 1..255
- SCW, 16, stall-counter width
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- id_valid  in  1  ID holds a real instruction
- id_rs, id_rt  in  AW  ID source register numbers
- id_use_rs, id_use_rt  in  1  instruction actually reads rs / rt
- id_md_start  in  1  ID instruction issues a mul/div (writes HI/LO)
- id_hilo_rd  in  1  ID instruction reads HI/LO (mfhi/mflo)
- e_wr, e_load  in  1  E-stage instruction writes GPR / is a load
- e_rn  in  AW  E-stage destination
- m_wr, m_load  in  1  M-stage writes GPR / is a load
- m_rn  in  AW  M-stage destination
- flush  in  1  ID instruction is being squashed this cycle
- clr_stats  in  1  synchronous clear of stall counter
- stall  out  1  freeze PC and IF/ID, bubble into E
- stall_cause  out  2  00 none, 01 load-use, 10 mul/div busy, 11 both
- fwda, fwdb  out  2  operand source: 00 RF, 01 E ALU, 10 M ALU, 11 M memory data
- md_busy  out  1  mul/div unit occupied
- md_done  out  1  one-cycle pulse, mul/div result valid in HI/LO
- stall_cnt  out  SCW  saturating count of stalled cycles

## Operation
- Forward, per operand X in {rs→fwda, rt→fwdb}, independent of id_use_*: E match (e_wr, e_rn≠0, e_rn==X, ~e_load) → 01; else M match non-load → 10; else M match load → 11; else 00. E has priority over M.
- Load-use hazard lu: id_valid & e_wr & e_load & e_rn≠0 & ((id_use_rs & e_rn==id_rs) | (id_use_rt & e_rn==id_rt)).
- Mul/div hazard mh: id_valid & (id_hilo_rd | id_md_start) & md_busy.
- stall = (lu | mh) & ~flush; stall_cause = {mh, lu} & {2{~flush}}.
- Issue accepted when id_valid & id_md_start & ~stall & ~flush.
- Countdown md_cnt (8 bits): accepted issue loads MD_LAT; else nonzero decrements; md_busy = (md_cnt≠0).
- md_done registered: set next cycle iff md_cnt==1 and no new load; else 0.
- flush never cancels an accepted mul/div; countdown continues.
- stall_cnt: clr_stats → 0 (priority); else stall & count≠all-ones → +1; saturates.

## Timing
- Reset (rst_n low, asynchronous): md_cnt=0, md_busy=0, md_done=0, stall_cnt=0. stall, stall_cause, fwda, fwdb stay combinational in inputs; with md_busy 0 only lu can assert.
- stall, stall_cause, fwda, fwdb: zero-latency combinational, same cycle as inputs.
- Issue accepted in cycle t → md_busy high t+1..t+MD_LAT, low at t+MD_LAT+1, md_done high exactly in t+MD_LAT+1.
- mfhi in ID at t+1..t+MD_LAT stalls; it proceeds at t+MD_LAT+1.
- Back-to-back issue: a second id_md_start at t+MD_LAT+1 is accepted (busy already low); md_done for the first still pulses in that cycle.
- Simultaneous lu and mh: stall_cause=11, counter +1 once.
- Reset mid-countdown: busy drops immediately (asynchronous); no md_done pulse.

## Structure
- Package pipe_hazard_pkg: forwarding encodings FWD_RF/FWD_EALU/FWD_MALU/FWD_MMEM, stall-cause constants, MD_LAT range check.
- One sub-module md_scoreboard_cnt (countdown, md_busy, md_done). Forwarding muxes, hazard logic and stall counter stay at top level.

## Test plan
- E=add to r8, M=lw to r8, ID reads rs=r8 → fwda=01, stall=0; remove E write → fwda=11.
- E=lw r9, ID use_rt with rt=r9 → stall=1, cause=01; same with e_rn=0 → stall=0, fwdb=00.
- MD_LAT=4, mul issued at t=10, mflo in ID from t=11 → stall 11–14, md_done=1 only at 15, stall_cnt=4.
- Stall conditions plus flush=1 → stall=0, no issue, stall_cnt unchanged.
- rst_n low at t+2 of countdown → md_busy=0 immediately, md_done never pulses, stall_cnt=0.
- SCW=4, hold stall 20 cycles → stall_cnt stops at 15; clr_stats with stall=1 → 0 next cycle.
